// File: rtl/serdes_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ valid/ready word streams into one serdes lane,
// granting one requester at a time for a burst of at most MAX_BURST accepted words.
module serdes_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4,
    localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BW        = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [GW-1:0]                 grant_id_o,
    output logic                          busy_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [GW-1:0]         r_grant;
    logic [GW-1:0]         r_last;
    logic [BW-1:0]         r_beats;
    logic [GW-1:0]         w_pick;
    logic                  w_any;
    logic                  w_sel_valid;
    logic                  w_beat;
    logic [DATA_WIDTH-1:0] w_word;

    function automatic logic [GW-1:0] wrap_idx(input int v);
        return GW'(v % NUM_REQ);
    endfunction

    // Walk the candidates from farthest to nearest so the requester closest
    // after last_grant is the one left in w_pick.
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_valid_i[wrap_idx(int'(r_last) + i)]) begin
                w_pick = wrap_idx(int'(r_last) + i);
                w_any  = 1'b1;
            end
        end
    end

    assign w_sel_valid = req_valid_i[r_grant];
    assign w_word      = req_data_i[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        valid_o     = 1'b0;
        data_o      = '0;
        req_ready_o = '0;
        w_beat      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) w_state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                valid_o              = w_sel_valid;
                data_o               = w_word;
                req_ready_o[r_grant] = ready_i;
                w_beat               = w_sel_valid & ready_i;
                if (!w_sel_valid || (w_beat && r_beats == BW'(MAX_BURST - 1)))
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= GW'(NUM_REQ - 1);
            r_beats <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_any) begin
                r_grant <= w_pick;
                r_beats <= '0;
            end else if (w_beat) begin
                r_beats <= r_beats + 1'b1;
            end
            if (r_state == ST_ACTIVE && w_state_nxt == ST_IDLE)
                r_last <= r_grant;
        end
    end

    assign busy_o     = (r_state == ST_ACTIVE);
    assign grant_id_o = r_grant;

endmodule

// File: tb/tb_serdes_arbiter.sv
// Bench for serdes_arbiter: directed scenarios plus randomized round-robin traffic
// scored against a queue-based reference model; a second instance covers MAX_BURST=1.
module tb_serdes_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_valid_i;
    logic [3:0]  req_ready_o;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic [1:0]  grant_id_o;
    logic        busy_o;

    logic [15:0] d2_data_i  = 16'h5AA5;
    logic [1:0]  d2_valid_i = 2'b11;
    logic        d2_ready_i = 1'b1;
    logic [1:0]  d2_ready_o;
    logic [7:0]  d2_data_o;
    logic        d2_valid_o;
    logic [0:0]  d2_grant;
    logic        d2_busy;

    always #5 clk = ~clk;

    serdes_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_data_i(req_data_i), .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .grant_id_o(grant_id_o), .busy_o(busy_o)
    );

    serdes_arbiter #(.DATA_WIDTH(8), .NUM_REQ(2), .MAX_BURST(1)) dut2 (
        .clk_i(clk), .rst_i(rst_i), .req_data_i(d2_data_i), .req_valid_i(d2_valid_i),
        .req_ready_o(d2_ready_o), .data_o(d2_data_o), .valid_o(d2_valid_o), .ready_i(d2_ready_i),
        .grant_id_o(d2_grant), .busy_o(d2_busy)
    );

    typedef struct {
        int gid;
        int data;
    } beat_t;

    int          tests_run = 0;
    int          tests_failed = 0;
    bit          mon_en = 1'b0;
    beat_t       exp_q[$];
    logic [7:0]  src_q[4][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < 4; k++) begin
            req_valid_i[k]        = (src_q[k].size() != 0);
            req_data_i[k*8 +: 8]  = (src_q[k].size() != 0) ? src_q[k][0] : 8'h00;
        end
    endtask

    // Called at a negedge; returns at the next negedge with inputs updated for accepted words.
    task automatic step(input logic next_ready);
        logic [3:0] hs;
        #1;
        hs = req_ready_o & req_valid_i;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++)
            if (hs[k]) void'(src_q[k].pop_front());
        ready_i = next_ready;
        drive_inputs();
        @(negedge clk);
    endtask

    task automatic clear_queues();
        for (int k = 0; k < 4; k++) src_q[k].delete();
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        ready_i = 1'b0;
        clear_queues();
        drive_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    // Scoreboard monitor: each offered-and-accepted word must match the next expected beat.
    always @(negedge clk) begin
        if (mon_en && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_beat", 32'd1, 32'd0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("sb_gid", 32'(grant_id_o), 32'(e.gid));
                check("sb_data", 32'(data_o), 32'(e.data));
            end
        end
    end

    initial begin
        int last;
        int grants_seen;
        int grants_exp;
        int beats;
        logic prev_busy;
        logic [7:0] mq[4][$];

        rst_i       = 1'b1;
        ready_i     = 1'b1;
        req_valid_i = 4'hF;
        req_data_i  = 32'hDEADBEEF;
        #2;
        check("rst_valid", 32'(valid_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_ready", 32'(req_ready_o), 0);
        check("rst_data", 32'(data_o), 0);
        check("rst_grant", 32'(grant_id_o), 0);
        @(negedge clk);

        // All four requesters valid, ready held: 0,1,2,3,0 with 4 beats and one bubble each.
        do_reset();
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 40; j++) src_q[k].push_back(8'((k << 6) | j));
        ready_i = 1'b1;
        drive_inputs();
        for (int c = 0; c < 25; c++) begin
            check("rr_busy", 32'(busy_o), 32'(c % 5 != 0));
            if (c % 5 != 0) begin
                check("rr_grant", 32'(grant_id_o), 32'((c / 5) % 4));
                check("rr_data", 32'(data_o), 32'((((c / 5) % 4) << 6) | ((c / 20) * 4 + (c % 5) - 1)));
            end
            if (c < 8) begin
                check("mb1_busy", 32'(d2_busy), 32'(c % 2));
                if (c % 2 == 1) check("mb1_grant", 32'(d2_grant), 32'(((c - 1) / 2) % 2));
            end
            step(1'b1);
        end

        // Requester 1 stalled by ready_i=0 for 5 cycles; afterwards a full 4-beat burst.
        do_reset();
        for (int j = 0; j < 6; j++) src_q[1].push_back(8'hA0 + 8'(j));
        drive_inputs();
        step(1'b0);
        for (int c = 0; c < 5; c++) begin
            check("stall_valid", 32'(valid_o), 1);
            check("stall_data", 32'(data_o), 32'hA0);
            check("stall_busy", 32'(busy_o), 1);
            check("stall_grant", 32'(grant_id_o), 1);
            step(1'b0);
        end
        ready_i = 1'b1;
        beats = 0;
        for (int c = 0; c < 10; c++) begin
            if (!busy_o) break;
            if (valid_o && ready_i) beats++;
            step(1'b1);
        end
        check("stall_burst_len", 32'(beats), 4);
        check("stall_left", 32'(src_q[1].size()), 2);

        // Requester 3 drops valid after 2 beats; next search starts at requester 0.
        do_reset();
        src_q[3].push_back(8'hB0);
        src_q[3].push_back(8'hB1);
        ready_i = 1'b1;
        drive_inputs();
        step(1'b1);
        check("drop_grant", 32'(grant_id_o), 3);
        for (int j = 0; j < 4; j++) begin
            src_q[0].push_back(8'hC0 + 8'(j));
            src_q[2].push_back(8'hD0 + 8'(j));
        end
        drive_inputs();
        #1;
        check("drop_other_valid_grant", 32'(grant_id_o), 3);
        check("drop_other_valid_data", 32'(data_o), 32'hB0);
        step(1'b1);
        step(1'b1);
        check("drop_busy_exit_cycle", 32'(busy_o), 1);
        check("drop_valid_low", 32'(valid_o), 0);
        check("drop_beats_taken", 32'(src_q[3].size()), 0);
        step(1'b1);
        check("drop_bubble", 32'(busy_o), 0);
        step(1'b1);
        check("drop_next_grant", 32'(grant_id_o), 0);
        check("drop_next_data", 32'(data_o), 32'hC0);

        // Reset pulsed during the 3rd beat of requester 1's burst.
        do_reset();
        for (int j = 0; j < 8; j++) src_q[1].push_back(8'hE0 + 8'(j));
        ready_i = 1'b1;
        drive_inputs();
        step(1'b1);
        step(1'b1);
        step(1'b1);
        check("mid_rst_pre_data", 32'(data_o), 32'hE2);
        rst_i = 1'b1;
        #1;
        check("mid_rst_valid", 32'(valid_o), 0);
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_ready", 32'(req_ready_o), 0);
        check("mid_rst_data", 32'(data_o), 0);
        check("mid_rst_grant", 32'(grant_id_o), 0);
        check("mid_rst_beats", 32'(src_q[1].size()), 6);
        clear_queues();
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) src_q[k].push_back(8'((k << 4) | j));
        drive_inputs();
        @(posedge clk);
        #1;
        check("rst_held_busy", 32'(busy_o), 0);
        check("rst_held_valid", 32'(valid_o), 0);
        @(negedge clk);
        rst_i = 1'b0;
        step(1'b1);
        check("post_rst_grant", 32'(grant_id_o), 0);
        check("post_rst_data", 32'(data_o), 32'h00);

        // Randomized traffic against the round-robin reference model.
        for (int round = 0; round < 8; round++) begin
            do_reset();
            for (int k = 0; k < 4; k++) begin
                int cnt;
                cnt = (round == 0) ? ((k == 2) ? 10 : 0) : int'($urandom_range(0, 9));
                for (int j = 0; j < cnt; j++) src_q[k].push_back(8'($urandom));
                mq[k] = src_q[k];
            end
            last = 3;
            grants_exp = 0;
            while (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() != 0) begin
                int k;
                int n;
                k = 0;
                for (int i = 4; i >= 1; i--)
                    if (mq[(last + i) % 4].size() != 0) k = (last + i) % 4;
                n = (mq[k].size() < 4) ? mq[k].size() : 4;
                for (int j = 0; j < n; j++) begin
                    beat_t b;
                    b.gid  = k;
                    b.data = int'(mq[k].pop_front());
                    exp_q.push_back(b);
                end
                last = k;
                grants_exp++;
            end
            ready_i = 1'b1;
            drive_inputs();
            mon_en = 1'b1;
            grants_seen = 0;
            prev_busy = 1'b0;
            for (int c = 0; c < 600; c++) begin
                if (src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() == 0 && !busy_o)
                    break;
                step($urandom_range(0, 99) < 70);
                if (busy_o && !prev_busy) grants_seen++;
                prev_busy = busy_o;
            end
            step(1'b1);
            step(1'b1);
            mon_en = 1'b0;
            check("rand_drained", 32'(src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()), 0);
            check("rand_exp_empty", 32'(exp_q.size()), 0);
            check("rand_grants", 32'(grants_seen), 32'(grants_exp));
            exp_q.delete();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
